// File: rtl/eth_rx_frame_ctrl_if.sv
// Frame controller bus: RMII dibit input, 32-bit payload word output and
// per-frame status. The master side is the frame controller.
interface eth_rx_frame_ctrl_if;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        axiov;
  logic [31:0] axiod;
  logic        axior;
  logic        frame_done;
  logic [1:0]  frame_status;
  logic [9:0]  frame_words;
  logic [15:0] ethertype;

  modport master (
    input  axiiv, axiid, axior,
    output axiov, axiod, frame_done, frame_status, frame_words, ethertype
  );

  modport slave (
    output axiiv, axiid, axior,
    input  axiov, axiod, frame_done, frame_status, frame_words, ethertype
  );
endinterface

// File: rtl/eth_rx_frame_ctrl.sv
// Receive frame sequencer: address filter, header skip, 32-bit payload word
// assembly with FCS removal, small output FIFO and per-frame status pulse.
module eth_rx_frame_ctrl #(
  parameter logic [47:0] MAC_ADDR   = 48'h69_69_5A_06_54_91,
  parameter bit          PROMISC    = 1'b0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  eth_rx_frame_ctrl_if.master bus
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_WAIT_IDLE, S_IDLE, S_DST, S_HDR, S_PAYLOAD, S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  dcnt_q;
  logic [3:0]  phase_q;
  logic        hold_vld_q;
  logic        ovf_q;
  logic [9:0]  words_q;
  logic [29:0] sh_q;
  logic [45:0] addr_q;
  logic [15:0] etype_q;
  logic [31:0] hold_q;
  logic        done_q;
  logic [1:0]  status_q;
  logic [9:0]  fwords_q;
  logic [15:0] fetype_q;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] cnt_q;

  logic [47:0] addr_full;
  logic        addr_ok;
  logic [31:0] word_full;
  logic        start, eof, word_done, push_req, push_ok, pop, full, fifo_ne;
  logic [1:0]  status_d;

  assign addr_full = {addr_q, bus.axiid};
  assign addr_ok   = PROMISC || (addr_full == MAC_ADDR) || (addr_full == '1);
  assign word_full = {sh_q, bus.axiid};
  assign fifo_ne   = (cnt_q != '0);
  assign full      = (cnt_q == DEPTH_C);
  assign pop       = fifo_ne && bus.axior;
  assign push_req  = word_done && hold_vld_q;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign push_ok   = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_WAIT_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_IDLE: if (!bus.axiiv) state_d = S_IDLE;
      S_IDLE:      if (bus.axiiv) state_d = S_DST;
      S_DST: begin
        if (!bus.axiiv)              state_d = S_IDLE;
        else if (dcnt_q == 6'd23)    state_d = addr_ok ? S_HDR : S_DROP;
      end
      S_HDR: begin
        if (!bus.axiiv)              state_d = S_IDLE;
        else if (dcnt_q == 6'd55)    state_d = S_PAYLOAD;
      end
      S_PAYLOAD, S_DROP: if (!bus.axiiv) state_d = S_IDLE;
      default: state_d = S_WAIT_IDLE;
    endcase
  end

  always_comb begin
    start     = 1'b0;
    eof       = 1'b0;
    word_done = 1'b0;
    status_d  = 2'd0;
    case (state_q)
      S_IDLE: start = bus.axiiv;
      S_DST, S_HDR: begin
        eof      = !bus.axiiv;
        status_d = 2'd2;
      end
      S_PAYLOAD: begin
        eof       = !bus.axiiv;
        word_done = bus.axiiv && (phase_q == 4'd15);
        status_d  = ((phase_q != 4'd0) || !hold_vld_q) ? 2'd2 : 2'd0;
      end
      S_DROP: begin
        eof      = !bus.axiiv;
        status_d = 2'd1;
      end
      default: ;
    endcase
    if (ovf_q) status_d = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_q     <= '0;
      phase_q    <= '0;
      hold_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      words_q    <= '0;
      done_q     <= 1'b0;
      status_q   <= '0;
      fwords_q   <= '0;
      fetype_q   <= '0;
    end else begin
      done_q <= eof;
      if (start) begin
        dcnt_q  <= 6'd1;
        words_q <= '0;
        ovf_q   <= 1'b0;
      end else if ((state_q == S_DST || state_q == S_HDR) && bus.axiiv) begin
        dcnt_q <= dcnt_q + 6'd1;
      end
      if (state_q == S_PAYLOAD && bus.axiiv) phase_q <= phase_q + 4'd1;
      if (word_done) hold_vld_q <= 1'b1;
      if (push_ok && words_q != 10'h3FF) words_q <= words_q + 10'd1;
      if (push_req && !push_ok) ovf_q <= 1'b1;
      if (eof) begin
        status_q   <= status_d;
        fwords_q   <= words_q;
        fetype_q   <= (state_q == S_PAYLOAD) ? etype_q : '0;
        dcnt_q     <= '0;
        phase_q    <= '0;
        hold_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.axiiv) sh_q <= {sh_q[27:0], bus.axiid};
    if (start || (state_q == S_DST && bus.axiiv)) addr_q <= {addr_q[43:0], bus.axiid};
    if (state_q == S_HDR && bus.axiiv && dcnt_q >= 6'd48) etype_q <= {etype_q[13:0], bus.axiid};
    if (word_done) hold_q <= word_full;
    if (push_ok) mem_q[wr_ptr_q] <= hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign bus.axiov        = fifo_ne;
  assign bus.axiod        = fifo_ne ? mem_q[rd_ptr_q] : '0;
  assign bus.frame_done   = done_q;
  assign bus.frame_status = status_q;
  assign bus.frame_words  = fwords_q;
  assign bus.ethertype    = fetype_q;
endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed bench for eth_rx_frame_ctrl: table of frames plus hand sequences
// for overflow, reset mid-frame and back-to-back frames under backpressure.
module tb_eth_rx_frame_ctrl;
  localparam logic [47:0] MAC = 48'h69_69_5A_06_54_91;

  typedef struct {
    logic [47:0] dst;
    logic [15:0] et;
    int          nw;
    bit          fcs;
    int          extra;
    int          trunc;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [1:0]  st;
    int          nwd;
    logic [15:0] xet;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_rx_frame_ctrl_if bus();

  eth_rx_frame_ctrl #(.MAC_ADDR(MAC), .PROMISC(1'b0), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] got_q [$];
  logic [27:0] done_q [$];
  logic [1:0]  fq [$];
  logic [31:0] wl [$];
  logic [1:0]  fa [$];
  logic [31:0] wa [$];
  bit          bp_toggle = 1'b0;
  vec_t        tbl [7];

  always @(negedge clk) begin
    if (bus.axiov && bus.axior) got_q.push_back(bus.axiod);
    if (bus.frame_done) done_q.push_back({bus.frame_status, bus.frame_words, bus.ethertype});
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] d);
    bus.axiiv = v;
    bus.axiid = d;
    if (bp_toggle) bus.axior = ~bus.axior;
    @(posedge clk);
    #1;
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 3; i >= 0; i--) fq.push_back(b[2*i +: 2]);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) add_byte(w[8*i +: 8]);
  endtask

  task automatic build(input vec_t v, input int idx);
    logic [47:0] src;
    logic [31:0] w;
    src = 48'h0010_A47B_EA80;
    fq.delete();
    wl.delete();
    for (int i = 5; i >= 0; i--) add_byte(v.dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) add_byte(src[8*i +: 8]);
    add_byte(v.et[15:8]);
    add_byte(v.et[7:0]);
    for (int k = 0; k < v.nw; k++) begin
      w = (k == 0) ? v.w0 : (k == 1) ? v.w1 : (32'h5A00_0000 ^ {16'(idx), 16'(k)});
      add_word(w);
      wl.push_back(w);
    end
    if (v.fcs) begin
      w = 32'hC0FF_EE00 + 32'(idx);
      add_word(w);
      wl.push_back(w);
    end
    for (int e = 0; e < v.extra; e++) fq.push_back(2'b10);
    if (v.trunc > 0) while (fq.size() > v.trunc) void'(fq.pop_back());
  endtask

  task automatic send_fq();
    for (int i = 0; i < fq.size(); i++) drive(1'b1, fq[i]);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          gb;
    int          db;
    logic [27:0] rec;
    gb = got_q.size();
    db = done_q.size();
    build(v, idx);
    send_fq();
    drive(1'b0, 2'b00);
    chk($sformatf("v%0d_done_pulse", idx), 48'(bus.frame_done), 48'd1);
    drive(1'b0, 2'b00);
    chk($sformatf("v%0d_done_single", idx), 48'(bus.frame_done), 48'd0);
    repeat (12) drive(1'b0, 2'b00);
    chk($sformatf("v%0d_done_cnt", idx), 48'(done_q.size() - db), 48'd1);
    if (done_q.size() > db) begin
      rec = done_q[db];
      chk($sformatf("v%0d_status", idx), 48'(rec[27:26]), 48'(v.st));
      chk($sformatf("v%0d_words", idx), 48'(rec[25:16]), 48'(v.nwd));
      chk($sformatf("v%0d_ethertype", idx), 48'(rec[15:0]), 48'(v.xet));
    end
    chk($sformatf("v%0d_word_cnt", idx), 48'(got_q.size() - gb), 48'(v.nwd));
    for (int i = 0; i < v.nwd && gb + i < got_q.size(); i++)
      chk($sformatf("v%0d_word%0d", idx, i), 48'(got_q[gb+i]), 48'(wl[i]));
  endtask

  initial begin
    int          gb;
    int          db;
    logic [27:0] rec;
    vec_t        v;

    tbl[0] = '{dst:MAC, et:16'h0800, nw:2, fcs:1'b1, extra:0, trunc:0,
               w0:32'hDEADBEEF, w1:32'h01234567, st:2'd0, nwd:2, xet:16'h0800};
    tbl[1] = '{dst:48'h0200_0000_0001, et:16'h0800, nw:2, fcs:1'b1, extra:0, trunc:0,
               w0:32'hDEADBEEF, w1:32'h01234567, st:2'd1, nwd:0, xet:16'h0000};
    tbl[2] = '{dst:48'hFFFF_FFFF_FFFF, et:16'h0800, nw:2, fcs:1'b1, extra:0, trunc:0,
               w0:32'hDEADBEEF, w1:32'h01234567, st:2'd0, nwd:2, xet:16'h0800};
    tbl[3] = '{dst:MAC, et:16'h0800, nw:2, fcs:1'b1, extra:0, trunc:40,
               w0:32'hDEADBEEF, w1:32'h01234567, st:2'd2, nwd:0, xet:16'h0000};
    tbl[4] = '{dst:MAC, et:16'h86DD, nw:3, fcs:1'b0, extra:8, trunc:0,
               w0:32'h1111_2222, w1:32'h3333_4444, st:2'd2, nwd:2, xet:16'h86DD};
    tbl[5] = '{dst:MAC, et:16'h88B5, nw:0, fcs:1'b0, extra:0, trunc:0,
               w0:32'h0, w1:32'h0, st:2'd2, nwd:0, xet:16'h88B5};
    tbl[6] = '{dst:MAC, et:16'h0806, nw:1, fcs:1'b1, extra:0, trunc:0,
               w0:32'hA5A5_0F0F, w1:32'h0, st:2'd0, nwd:1, xet:16'h0806};

    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;
    bus.axior = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_axiov", 48'(bus.axiov), 48'd0);
    chk("rst_axiod", 48'(bus.axiod), 48'd0);
    chk("rst_frame_done", 48'(bus.frame_done), 48'd0);
    chk("rst_frame_status", 48'(bus.frame_status), 48'd0);
    chk("rst_frame_words", 48'(bus.frame_words), 48'd0);
    chk("rst_ethertype", 48'(bus.ethertype), 48'd0);
    rst = 1'b0;
    repeat (3) drive(1'b0, 2'b00);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Overflow: 7 payload words + FCS into a 4-deep FIFO with no drain.
    bus.axior = 1'b0;
    gb = got_q.size();
    db = done_q.size();
    v = tbl[0];
    v.nw = 7;
    build(v, 10);
    send_fq();
    repeat (12) drive(1'b0, 2'b00);
    chk("ovf_done_cnt", 48'(done_q.size() - db), 48'd1);
    if (done_q.size() > db) begin
      rec = done_q[db];
      chk("ovf_status", 48'(rec[27:26]), 48'd3);
      chk("ovf_words", 48'(rec[25:16]), 48'd4);
    end
    chk("ovf_no_pop", 48'(got_q.size() - gb), 48'd0);
    chk("ovf_axiov", 48'(bus.axiov), 48'd1);
    chk("ovf_axiod_stable", 48'(bus.axiod), 48'(wl[0]));
    bus.axior = 1'b1;
    repeat (10) drive(1'b0, 2'b00);
    chk("ovf_drain_cnt", 48'(got_q.size() - gb), 48'd4);
    for (int i = 0; i < 4 && gb + i < got_q.size(); i++)
      chk($sformatf("ovf_word%0d", i), 48'(got_q[gb+i]), 48'(wl[i]));

    // Reset mid-frame with two words already waiting in the FIFO.
    bus.axior = 1'b0;
    build(tbl[0], 11);
    send_fq();
    repeat (8) drive(1'b0, 2'b00);
    chk("rmf_preload", 48'(bus.axiov), 48'd1);
    gb = got_q.size();
    db = done_q.size();
    v = tbl[0];
    v.nw = 4;
    build(v, 12);
    for (int i = 0; i < fq.size(); i++) begin
      rst = (i == 69);
      drive(1'b1, fq[i]);
    end
    rst = 1'b0;
    repeat (8) drive(1'b0, 2'b00);
    chk("rmf_no_done", 48'(done_q.size() - db), 48'd0);
    chk("rmf_fifo_empty", 48'(bus.axiov), 48'd0);
    bus.axior = 1'b1;
    repeat (6) drive(1'b0, 2'b00);
    chk("rmf_no_words", 48'(got_q.size() - gb), 48'd0);
    run_vec(tbl[0], 13);

    // Back-to-back frames, one low cycle apart, ready toggling each cycle.
    gb = got_q.size();
    db = done_q.size();
    v = tbl[0];
    v.w0 = 32'h0A0B_0C0D;
    v.w1 = 32'h1020_3040;
    build(v, 14);
    fa = fq;
    wa = wl;
    v.w0 = 32'hFEED_FACE;
    v.w1 = 32'h7654_3210;
    build(v, 15);
    bp_toggle = 1'b1;
    for (int i = 0; i < fa.size(); i++) drive(1'b1, fa[i]);
    drive(1'b0, 2'b00);
    send_fq();
    repeat (30) drive(1'b0, 2'b00);
    bp_toggle = 1'b0;
    bus.axior = 1'b1;
    chk("b2b_done_cnt", 48'(done_q.size() - db), 48'd2);
    for (int i = 0; i < 2 && db + i < done_q.size(); i++) begin
      rec = done_q[db+i];
      chk($sformatf("b2b_status%0d", i), 48'(rec[27:26]), 48'd0);
      chk($sformatf("b2b_words%0d", i), 48'(rec[25:16]), 48'd2);
    end
    chk("b2b_word_cnt", 48'(got_q.size() - gb), 48'd4);
    if (got_q.size() - gb == 4) begin
      chk("b2b_word0", 48'(got_q[gb]),   48'(wa[0]));
      chk("b2b_word1", 48'(got_q[gb+1]), 48'(wa[1]));
      chk("b2b_word2", 48'(got_q[gb+2]), 48'(wl[0]));
      chk("b2b_word3", 48'(got_q[gb+3]), 48'(wl[1]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
